// File: rtl/hdmi_video_pkg.sv
// Shared video constants, types and Sobel arithmetic helpers for the HDMI edge pipeline.
package hdmi_video_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]        mag_t;

  localparam pix_t EDGE_ON  = 8'hFF;
  localparam pix_t EDGE_OFF = 8'h00;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } sync_t;

  // (p0 + 2*p1 + p2) - (n0 + 2*n1 + n2); both sums fit in 10 bits, so 11 signed bits never overflow.
  function automatic grad_t sobel_diff(input pix_t p0, input pix_t p1, input pix_t p2,
                                       input pix_t n0, input pix_t n1, input pix_t n2);
    mag_t pos;
    mag_t neg;
    pos = GRAD_W'(p0) + GRAD_W'({p1, 1'b0}) + GRAD_W'(p2);
    neg = GRAD_W'(n0) + GRAD_W'({n1, 1'b0}) + GRAD_W'(n2);
    return grad_t'(pos - neg);
  endfunction

  function automatic mag_t abs_grad(input grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

endpackage

// File: rtl/hdmi_sobel_edge_if.sv
// Raster video stream bundle: syncs, data enable and one 8-bit pixel channel.
interface hdmi_sobel_edge_if;
  import hdmi_video_pkg::*;

  logic vs;
  logic hs;
  logic de;
  pix_t pix;

  modport master (output vs, hs, de, pix);
  modport slave  (input  vs, hs, de, pix);
endinterface

// File: rtl/hdmi_sobel_edge_line_buffer.sv
// One video line of pixel storage: simple dual-port RAM with a registered, enabled read.
module line_buffer
  import hdmi_video_pkg::*;
#(
  parameter int DEPTH = 1280,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pix_t          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output pix_t          rd_data
);

  pix_t mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto block RAM; stale data is masked downstream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hdmi_sobel_edge.sv
// Sobel edge detector on a grayscale HDMI stream: 3x3 window over two line buffers, fixed 4-cycle latency.
module hdmi_sobel_edge
  import hdmi_video_pkg::*;
#(
  parameter int IMG_WIDTH = 1280,
  parameter int EDGE_TH   = 128
) (
  input  logic       pixclk_in,
  input  logic       rst,
  input  logic       vs_in,
  input  logic       hs_in,
  input  logic       de_in,
  input  logic [7:0] gray_in,
  output logic       pixclk_out,
  output logic       vs_out,
  output logic       hs_out,
  output logic       de_out,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out
);

  localparam int   AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam mag_t TH = GRAD_W'(EDGE_TH);

  assign pixclk_out = pixclk_in;

  // Input-side position tracking
  logic          de_q, vs_q, frame_ok;
  logic [AW-1:0] col;
  logic [15:0]   row;
  logic          de_fall, vs_rise;

  assign de_fall = de_q & ~de_in;
  assign vs_rise = vs_in & ~vs_q;

  // frame_ok stays low after reset until a fresh frame starts, so a partial frame never reaches the output.
  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      frame_ok <= 1'b0;
      col      <= '0;
      row      <= '0;
    end else begin
      de_q <= de_in;
      vs_q <= vs_in;
      if (de_in)        col <= (col == AW'(IMG_WIDTH - 1)) ? '0 : col + 1'b1;
      else if (de_fall) col <= '0;
      if (vs_rise) begin
        row      <= '0;
        frame_ok <= 1'b1;
      end else if (de_fall && row != '1) begin
        row <= row + 1'b1;
      end
    end
  end

  // S1: line-buffer read and window shift
  pix_t          lb0_q, lb1_q, gray_s1;
  pix_t          top_l, top_c, mid_l, mid_c, bot_l, bot_c;
  sync_t         s1_sync;
  logic [AW-1:0] col_s1;
  logic          ok_s1;

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk     (pixclk_in),
    .wr_en   (de_in),
    .wr_addr (col),
    .wr_data (gray_in),
    .rd_en   (de_in),
    .rd_addr (col),
    .rd_data (lb0_q)
  );

  // Line 1 is written one cycle late with what line 0 held, after its own read of that column.
  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (pixclk_in),
    .wr_en   (s1_sync.de),
    .wr_addr (col_s1),
    .wr_data (lb0_q),
    .rd_en   (de_in),
    .rd_addr (col),
    .rd_data (lb1_q)
  );

  // The right window column is {lb1_q, lb0_q, gray_s1}; the registers below hold columns c-1 and c-2.
  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      s1_sync <= '0;
      col_s1  <= '0;
      ok_s1   <= 1'b0;
      gray_s1 <= '0;
      top_l   <= '0;
      top_c   <= '0;
      mid_l   <= '0;
      mid_c   <= '0;
      bot_l   <= '0;
      bot_c   <= '0;
    end else begin
      s1_sync <= {vs_in, hs_in, de_in};
      col_s1  <= col;
      if (de_in) begin
        ok_s1   <= frame_ok && (row >= 16'd2) && (col >= AW'(2));
        gray_s1 <= gray_in;
        top_l   <= top_c;
        top_c   <= lb1_q;
        mid_l   <= mid_c;
        mid_c   <= lb0_q;
        bot_l   <= bot_c;
        bot_c   <= gray_s1;
      end
    end
  end

  // S2: gradients, S3: magnitude and threshold, S4: output register
  grad_t gx_s2, gy_s2;
  sync_t s2_sync, s3_sync;
  logic  ok_s2, edge_s3;
  mag_t  mag;

  assign mag = abs_grad(gx_s2) + abs_grad(gy_s2);

  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      s2_sync <= '0;
      ok_s2   <= 1'b0;
      gx_s2   <= '0;
      gy_s2   <= '0;
      s3_sync <= '0;
      edge_s3 <= 1'b0;
      vs_out  <= 1'b0;
      hs_out  <= 1'b0;
      de_out  <= 1'b0;
      r_out   <= EDGE_OFF;
      g_out   <= EDGE_OFF;
      b_out   <= EDGE_OFF;
    end else begin
      s2_sync <= s1_sync;
      ok_s2   <= ok_s1 & s1_sync.de;
      gx_s2   <= sobel_diff(lb1_q, lb0_q, gray_s1, top_l, mid_l, bot_l);
      gy_s2   <= sobel_diff(bot_l, bot_c, gray_s1, top_l, top_c, lb1_q);

      s3_sync <= s2_sync;
      edge_s3 <= ok_s2 && (mag > TH);

      vs_out  <= s3_sync.vs;
      hs_out  <= s3_sync.hs;
      de_out  <= s3_sync.de;
      r_out   <= (s3_sync.de && edge_s3) ? EDGE_ON : EDGE_OFF;
      g_out   <= (s3_sync.de && edge_s3) ? EDGE_ON : EDGE_OFF;
      b_out   <= (s3_sync.de && edge_s3) ? EDGE_ON : EDGE_OFF;
    end
  end

endmodule

// File: tb/tb_hdmi_sobel_edge.sv
// Directed and reference-model checks for hdmi_sobel_edge: latency, reset, step edges, thresholds, random frame.
module tb_hdmi_sobel_edge;
  import hdmi_video_pkg::*;

  localparam int TH = 128;

  logic pixclk_in = 1'b0;
  logic rst       = 1'b1;
  logic pixclk_out;
  pix_t g_out, b_out;

  always #5 pixclk_in = ~pixclk_in;

  hdmi_sobel_edge_if vin ();
  hdmi_sobel_edge_if vout ();

  hdmi_sobel_edge #(.IMG_WIDTH(1280), .EDGE_TH(TH)) dut (
    .pixclk_in  (pixclk_in),
    .rst        (rst),
    .vs_in      (vin.vs),
    .hs_in      (vin.hs),
    .de_in      (vin.de),
    .gray_in    (vin.pix),
    .pixclk_out (pixclk_out),
    .vs_out     (vout.vs),
    .hs_out     (vout.hs),
    .de_out     (vout.de),
    .r_out      (vout.pix),
    .g_out      (g_out),
    .b_out      (b_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  img [16][64];
  logic [23:0] capq [$];

  // Outputs change on the rising edge; capture on the falling edge.
  always @(negedge pixclk_in) if (vout.de) capq.push_back({vout.pix, g_out, b_out});

  task automatic drive(input logic vs, input logic hs, input logic de, input pix_t px);
    vin.vs  = vs;
    vin.hs  = hs;
    vin.de  = de;
    vin.pix = px;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pixclk_in);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  // rst_row >= 0 pulses rst for three cycles at cols 5..7 of that row and checks the outputs cleared.
  task automatic send_frame(input int w, input int h, input int rst_row);
    capq.delete();
    repeat (2) begin
      @(negedge pixclk_in);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
    idle(3);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        @(negedge pixclk_in);
        if (r == rst_row && c == 6) begin
          check("rst_vs_out", 32'(vout.vs),  32'd0);
          check("rst_hs_out", 32'(vout.hs),  32'd0);
          check("rst_de_out", 32'(vout.de),  32'd0);
          check("rst_rgb",    {8'h00, vout.pix, g_out, b_out}, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b1, img[r][c]);
        rst = (r == rst_row) && (c >= 5) && (c <= 7);
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge pixclk_in);
        rst = 1'b0;
        drive(1'b0, (k == 1), 1'b0, 8'h00);
      end
    end
  endtask

  function automatic logic [7:0] ref_pix(input int r, input int c);
    int gx, gy, mag;
    if (r < 2 || c < 2) return 8'h00;
    gx = (int'(img[r-2][c]) + 2*int'(img[r-1][c]) + int'(img[r][c]))
       - (int'(img[r-2][c-2]) + 2*int'(img[r-1][c-2]) + int'(img[r][c-2]));
    gy = (int'(img[r][c-2]) + 2*int'(img[r][c-1]) + int'(img[r][c]))
       - (int'(img[r-2][c-2]) + 2*int'(img[r-2][c-1]) + int'(img[r-2][c]));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > TH) ? 8'hFF : 8'h00;
  endfunction

  // mode: 0 all zero, 1 vertical step at col 8, 2 horizontal step at row 4, 3 reference model
  function automatic logic [7:0] exp_pix(input int mode, input int r, input int c);
    case (mode)
      1:       return (r >= 2 && (c == 8 || c == 9)) ? 8'hFF : 8'h00;
      2:       return (c >= 2 && (r == 4 || r == 5)) ? 8'hFF : 8'h00;
      3:       return ref_pix(r, c);
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_frame(input string name, input int w, input int h, input int mode);
    logic [7:0] e;
    idle(8);
    check($sformatf("%s_count", name), 32'(capq.size()), 32'(w * h));
    for (int i = 0; i < w * h && i < capq.size(); i++) begin
      e = exp_pix(mode, i / w, i % w);
      check($sformatf("%s_r%0d_c%0d", name, i / w, i % w), 32'(capq[i]), {8'h00, e, e, e});
    end
  endtask

  task automatic fill(input int kind, input int amp);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++)
        case (kind)
          0:       img[r][c] = 8'(amp);
          1:       img[r][c] = (c >= 8) ? 8'(amp) : 8'h00;
          2:       img[r][c] = (r >= 4) ? 8'(amp) : 8'h00;
          default: img[r][c] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : img[r][(c == 0) ? 0 : c-1];
        endcase
  endtask

  // {vs, hs, de} applied cycle by cycle; each must reappear 4 cycles later.
  logic [2:0] lat_in [16] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b010, 3'b100, 3'b000, 3'b000,
                              3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [3:0] lat_out [16];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 64; c++)
        img[r][c] = 8'h00;
    repeat (3) @(negedge pixclk_in);
    check("reset_vs_out", 32'(vout.vs), 32'd0);
    check("reset_hs_out", 32'(vout.hs), 32'd0);
    check("reset_de_out", 32'(vout.de), 32'd0);
    check("reset_rgb",    {8'h00, vout.pix, g_out, b_out}, 32'd0);
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < 16; i++) begin
      @(negedge pixclk_in);
      lat_out[i] = {vout.vs, vout.hs, vout.de, |{vout.pix, g_out, b_out}};
      drive(lat_in[i][2], lat_in[i][1], lat_in[i][0], 8'hAA);
    end
    for (int i = 0; i < 12; i++)
      check($sformatf("latency_%0d", i), 32'(lat_out[i+4]), 32'({lat_in[i], 1'b0}));

    fill(0, 100);
    send_frame(16, 8, -1);
    check_frame("flat", 16, 8, 0);

    fill(1, 200);
    send_frame(16, 8, -1);
    check_frame("vstep", 16, 8, 1);

    fill(2, 32);
    send_frame(16, 8, -1);
    check_frame("hstep32", 16, 8, 0);

    fill(2, 33);
    send_frame(16, 8, -1);
    check_frame("hstep33", 16, 8, 2);

    fill(1, 200);
    send_frame(16, 8, 3);
    idle(8);
    send_frame(16, 8, -1);
    check_frame("after_rst", 16, 8, 1);

    fill(3, 0);
    send_frame(64, 16, -1);
    check_frame("random", 64, 16, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
